// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: decoder-side control/instruction signals plus the
// instruction-memory read handshake. master = fetch unit, slave = environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              en_pc;
  logic              pc_mux_en;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    input  en_pc, pc_mux_en, branch_target, mem_rdata, mem_valid, instr_ready,
    output mem_addr, mem_rd, instr, instr_pc, instr_valid
  );

  modport slave (
    output en_pc, pc_mux_en, branch_target, mem_rdata, mem_valid, instr_ready,
    input  mem_addr, mem_rd, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// valid/hold handshake and presents each word to the decoder in a holding register.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_reqAddr;
  logic [ADDR_W-1:0] r_instrPc;
  logic [15:0]       r_instr;
  logic              r_instrValid;
  logic              r_squash;
  logic              w_issue;

  assign w_issue = (r_state == ST_FETCH) && bus.en_pc && !bus.pc_mux_en;

  // A redirect in WAIT moves the PC, but the outstanding request address must
  // stay put until memory answers, so WAIT drives the latched request address.
  assign bus.mem_rd      = !reset && (w_issue || (r_state == ST_WAIT));
  assign bus.mem_addr    = (r_state == ST_WAIT) ? r_reqAddr : r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instrPc;
  assign bus.instr_valid = r_instrValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_reqAddr    <= RESET_PC;
      r_instrPc    <= '0;
      r_instr      <= '0;
      r_instrValid <= 1'b0;
      r_squash     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.pc_mux_en) begin
            r_pc <= bus.branch_target;
          end else if (bus.en_pc) begin
            r_reqAddr <= r_pc;
            r_state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.mem_valid) begin
            if (r_squash || bus.pc_mux_en) begin
              r_squash <= 1'b0;
              if (bus.pc_mux_en) begin
                r_pc <= bus.branch_target;
              end
              r_state <= ST_FETCH;
            end else begin
              r_instr      <= bus.mem_rdata;
              r_instrPc    <= r_pc;
              r_pc         <= r_pc + ADDR_W'(1);
              r_instrValid <= 1'b1;
              r_state      <= ST_HOLD;
            end
          end else if (bus.pc_mux_en) begin
            // Word in flight belongs to the old path; drop it when it lands.
            r_squash <= 1'b1;
            r_pc     <= bus.branch_target;
          end
        end

        ST_HOLD: begin
          if (bus.pc_mux_en) begin
            r_pc         <= bus.branch_target;
            r_instrValid <= 1'b0;
            r_state      <= ST_FETCH;
          end else if (bus.instr_ready) begin
            r_instrValid <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end

        default: r_state <= ST_FETCH;
      endcase
    end
  end
endmodule
